// File: rtl/program_loader.sv
// Boot loader that receives a program image over a UART byte stream and writes it
// word by word into program memory, then releases the CPU (or flags an abort).
module program_loader #(
    parameter int ADDR_LENGTH    = 11,
    parameter int DATA_LENGTH    = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_done,
    output logic [ADDR_LENGTH-1:0] mem_addr,
    output logic [DATA_LENGTH-1:0] mem_data,
    output logic                   mem_wr,
    output logic                   busy,
    output logic                   cpu_en,
    output logic                   error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_LENGTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CNT_LO  = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        DONE    = 3'd4,
        ERROR   = 3'd5
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [15:0]     count_reg;
    logic [15:0]     word_cnt_reg;
    logic [TW-1:0]   tcnt_reg;

    logic [15:0]     full_count;
    logic            timeout_hit;
    logic            last_word;

    // The low count byte is still on rx_data when the count is evaluated.
    assign full_count  = {count_reg[15:8], rx_data};
    assign timeout_hit = !rx_done && (tcnt_reg == TW'(TIMEOUT_CYCLES - 1));
    assign last_word   = (word_cnt_reg == count_reg - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (rx_done) state_next = CNT_LO;
            end
            CNT_LO: begin
                if (rx_done) begin
                    if (full_count == 16'd0)
                        state_next = DONE;
                    else if (32'(full_count) > MAX_WORDS)
                        state_next = ERROR;
                    else
                        state_next = DATA_HI;
                end else if (timeout_hit) begin
                    state_next = ERROR;
                end
            end
            DATA_HI: begin
                if (rx_done)          state_next = DATA_LO;
                else if (timeout_hit) state_next = ERROR;
            end
            DATA_LO: begin
                if (rx_done)          state_next = last_word ? DONE : DATA_HI;
                else if (timeout_hit) state_next = ERROR;
            end
            DONE:    state_next = DONE;
            ERROR:   state_next = ERROR;
            default: state_next = ERROR;
        endcase
    end

    always_comb begin
        busy   = (state_reg == CNT_LO) || (state_reg == DATA_HI) || (state_reg == DATA_LO);
        cpu_en = (state_reg == DONE);
        error  = (state_reg == ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= '0;
            word_cnt_reg <= '0;
            mem_data     <= '0;
            mem_wr       <= 1'b0;
            mem_addr     <= '0;
        end else begin
            mem_wr <= 1'b0;
            if (rx_done && state_reg == IDLE)   count_reg[15:8] <= rx_data;
            if (rx_done && state_reg == CNT_LO) count_reg[7:0]  <= rx_data;
            if (rx_done && state_reg == DATA_HI) mem_data[15:8] <= rx_data;
            if (rx_done && state_reg == DATA_LO) begin
                mem_data[7:0] <= rx_data;
                mem_wr        <= 1'b1;
                word_cnt_reg  <= word_cnt_reg + 16'd1;
            end
            // After the final write the FSM already sits in DONE, so the address never wraps.
            if (mem_wr && state_reg != DONE)
                mem_addr <= mem_addr + ADDR_LENGTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_reg <= '0;
        end else if (rx_done || (state_next != state_reg) || !busy) begin
            tcnt_reg <= '0;
        end else begin
            tcnt_reg <= tcnt_reg + TW'(1);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: stimulus pushes expected writes into a queue,
// an independent monitor pops and compares every mem_wr pulse.
module tb_program_loader;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_done = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          mem_wr;
    logic          busy;
    logic          cpu_en;
    logic          error;

    int checks = 0;
    int failures = 0;
    logic [AW+15:0] sb[$];

    program_loader #(
        .ADDR_LENGTH(AW),
        .DATA_LENGTH(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_wr(mem_wr),
        .busy(busy),
        .cpu_en(cpu_en),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    initial begin
        logic [AW+15:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n && mem_wr) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", mem_addr, mem_data);
                end else begin
                    exp = sb.pop_front();
                    if ({mem_addr, mem_data} !== exp) begin
                        failures++;
                        $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                                 mem_addr, mem_data, exp[AW+15:16], exp[15:0]);
                    end else begin
                        $display("ok   write addr 0x%0h data 0x%0h", mem_addr, mem_data);
                    end
                end
            end
        end
    end

    // Called at posedge+1; drives a one-cycle strobe and returns at the next posedge+1.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [15:0] d);
        sb.push_back({a, d});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx_done = 1'b0;
        #2;
        check("rst_outputs", {mem_addr, mem_data, mem_wr, busy, cpu_en, error}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic end_of_test(input string name);
        idle(2);
        check({name, "_pending_writes"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        // Two-word load.
        do_reset();
        expect_write(11'h000, 16'h1001);
        expect_write(11'h001, 16'h2002);
        send_byte(8'h00);
        check("t1_busy_cnt_lo", busy, 1);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h01);
        send_byte(8'h20);
        send_byte(8'h02);
        idle(1);
        check("t1_cpu_en", cpu_en, 1);
        check("t1_busy", busy, 0);
        check("t1_error", error, 0);
        end_of_test("t1");

        // Zero-length program.
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
        idle(1);
        check("t2_cpu_en", cpu_en, 1);
        check("t2_error", error, 0);
        end_of_test("t2");

        // Count 2049 exceeds capacity.
        do_reset();
        send_byte(8'h08);
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h01);
        idle(1);
        check("t3_error", error, 1);
        check("t3_cpu_en", cpu_en, 0);
        check("t3_busy", busy, 0);
        end_of_test("t3");

        // Full 2048-word image, bytes back to back (high byte lands in the write cycle).
        do_reset();
        send_byte(8'h08);
        send_byte(8'h00);
        for (int i = 0; i < 2048; i++) begin
            logic [15:0] w;
            w = 16'(i * 3 + 16'h5A01);
            expect_write(11'(i), w);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        send_byte(8'h12);
        send_byte(8'h34);
        idle(1);
        check("t4_cpu_en", cpu_en, 1);
        check("t4_last_addr", mem_addr, 11'h7FF);
        check("t4_error", error, 0);
        end_of_test("t4");

        // Timeout: 16 idle clocks after a high byte aborts the load.
        do_reset();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h10);
        idle(16);
        check("t5_timeout_error", error, 1);
        check("t5_timeout_busy", busy, 0);
        send_byte(8'h01);
        end_of_test("t5");

        // Timeout boundary: 15 idle clocks is still in time.
        do_reset();
        expect_write(11'h000, 16'h1001);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h10);
        idle(15);
        check("t6_no_error_yet", error, 0);
        send_byte(8'h01);
        idle(1);
        check("t6_cpu_en", cpu_en, 1);
        check("t6_error", error, 0);
        end_of_test("t6");

        // Reset between high and low byte of word 1, then a fresh load.
        do_reset();
        expect_write(11'h000, 16'h1122);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("t7_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #2;
        check("t7_async_rst_outputs", {mem_addr, mem_data, mem_wr, busy, cpu_en, error}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("t7_sb_after_rst", sb.size(), 0);
        expect_write(11'h000, 16'hABCD);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAB);
        send_byte(8'hCD);
        idle(1);
        check("t7_cpu_en", cpu_en, 1);
        end_of_test("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
